uart_rx_word: RTL
=================

UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 5208, clk cycles per half UART bit; must be >= 2.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20, inter-byte timeout in bit periods; used only when UART_RX_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all logic.
REQ-004 SHALL have port rstn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rdata, output, 32, assembled word.
REQ-007 SHALL have port valid, output, 1, rdata holds a complete word.
REQ-008 SHALL have port ready, input, 1, consumer accepts rdata.
REQ-009 SHALL have port rx_busy, output, 1, a word is partially or actively received.
REQ-010 SHALL have port ferr, output, 1, one-cycle framing-error pulse.
REQ-011 SHALL have port overrun, output, 1, sticky; a word was dropped.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 SHALL use 8N1 framing, LSB first; 4 bytes per word, first byte into rdata[7:0], fourth into rdata[31:24].
REQ-014 SHALL run states IDLE, START, DATA, STOP; IDLE -> START on synchronized falling edge (high then low).
REQ-015 SHALL in START re-sample after CLK_PER_HALF_BIT cycles; low -> DATA, high -> IDLE (false start, nothing recorded).
REQ-016 SHALL in DATA sample each bit every 2*CLK_PER_HALF_BIT cycles from the start mid-point; after 8 bits -> STOP.
REQ-017 SHALL in STOP sample once at mid-bit; high -> byte accepted, byte count += 1, -> IDLE immediately (next start detectable next cycle).
REQ-018 SHALL on STOP sample low: discard byte and partial word, byte count -> 0, ferr high one cycle, stay IDLE until rxd seen high.
REQ-019 SHALL on acceptance of the 4th byte load rdata and assert valid on the following cycle; byte count wraps to 0.
REQ-020 SHALL keep valid and rdata stable until a cycle with valid && ready; valid drops the next cycle.
REQ-021 SHALL, if a word completes while valid is high and ready low in that cycle, drop the new word, keep old rdata, set overrun; ready high in the same cycle accepts old and loads new, no overrun.
REQ-022 SHALL drive rx_busy high when state != IDLE or byte count != 0.

Reset
REQ-023 SHALL on rstn low: state IDLE, byte count 0, rdata 0, valid 0, ferr 0, overrun 0, rx_busy 0, synchronizer flops 1.
REQ-024 SHALL abort any byte or word in progress on reset; overrun clears only by reset.

Configuration
REQ-025 SHALL with UART_RX_TIMEOUT_EN defined: byte count 1..3 and IDLE for TIMEOUT_BITS*2*CLK_PER_HALF_BIT cycles -> byte count 0, partial word discarded, no output.
REQ-026 SHALL without UART_RX_TIMEOUT_EN: partial word held indefinitely; no timeout counter synthesized.

Structure
REQ-027 SHALL place the state enum and the UART_DATA_BITS=8, BYTES_PER_WORD=4 constants in shared package uart_pkg.
REQ-028 SHALL implement the per-byte receiver (sync, START/DATA/STOP, ferr) as sub-module uart_rx_byte; uart_rx_word does assembly, handshake, timeout.

Verification (CLK_PER_HALF_BIT=4, TIMEOUT_BITS=20)
REQ-029 SHALL cover: bytes 0x78,0x56,0x34,0x12 with ready low -> rdata=0x12345678, valid held; ready high one cycle -> valid 0 next cycle.
REQ-030 SHALL cover: rxd low pulse of 2 cycles in IDLE -> no byte, rx_busy stays 0.
REQ-031 SHALL cover: second byte with stop=0 -> ferr one pulse, count 0; then 0xEF,0xBE,0xAD,0xDE -> rdata=0xDEADBEEF.
REQ-032 SHALL cover: two full words with ready low -> rdata keeps first word, overrun=1.
REQ-033 SHALL cover: rstn low mid-DATA of byte 3 -> all outputs at reset values; next full word received correctly.
REQ-034 SHALL cover (macro defined): 2 bytes, idle 21 bit periods, then 0x01,0x02,0x03,0x04 -> rdata=0x04030201; macro undefined -> rdata=0x02010201 word not formed until fourth byte, i.e. 0x02_01_<b2>_<b1>.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive constants and state encoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: input synchronizer, start/data/stop sampling, framing error
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      done,
  output logic                      ferr,
  output logic                      busy
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_next;
  logic                      sync1;
  logic                      sync2;
  logic                      prev;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      tick_half;
  logic                      tick_full;

  assign tick_half = (cnt == HALF_LAST);
  assign tick_full = (cnt == FULL_LAST);
  assign data      = shreg;

  // prev trails the synchronized line so a start needs a high-to-low transition;
  // after a framing error the line must return high before the next start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (prev && !sync2) state_next = ST_START;
      ST_START: if (tick_half) state_next = sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick_full && bit_idx == BIT_LAST) state_next = ST_STOP;
      ST_STOP:  if (tick_full) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    ferr = 1'b0;
    busy = (state != ST_IDLE);
    if (state == ST_STOP && tick_full) begin
      done = sync2;
      ferr = !sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == ST_IDLE || state_next != state || tick_full) cnt <= '0;
      else                                                       cnt <= cnt + CW'(1);
      if (state == ST_START)
        bit_idx <= '0;
      else if (state == ST_DATA && tick_full)
        bit_idx <= bit_idx + BW'(1);
      if (state == ST_DATA && tick_full)
        shreg <= {sync2, shreg[UART_DATA_BITS-1:1]};
    end
  end
endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 32-bit word assembler with valid/ready hold and overrun; UART_RX_TIMEOUT_EN adds inter-byte timeout
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        ready,
  output logic        rx_busy,
  output logic        ferr,
  output logic        overrun
);
  localparam int CNTW = $clog2(BYTES_PER_WORD);
  localparam logic [CNTW-1:0] LAST_BYTE = CNTW'(BYTES_PER_WORD - 1);
  localparam int PW = UART_DATA_BITS * (BYTES_PER_WORD - 1);

  logic [UART_DATA_BITS-1:0] byte_data;
  logic                      byte_done;
  logic                      byte_ferr;
  logic                      byte_busy;
  logic [CNTW-1:0]           byte_cnt;
  logic [PW-1:0]             partial;
  logic                      word_done;
  logic                      timeout;

  uart_rx_byte #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_byte (
    .clk (clk),
    .rstn(rstn),
    .rxd (rxd),
    .data(byte_data),
    .done(byte_done),
    .ferr(byte_ferr),
    .busy(byte_busy)
  );

  assign word_done = byte_done && (byte_cnt == LAST_BYTE);
  assign rx_busy   = byte_busy || (byte_cnt != '0);
  assign ferr      = byte_ferr;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * 2 * CLK_PER_HALF_BIT;
  localparam int TW = $clog2(TO_CYCLES);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || byte_busy || byte_cnt == '0) idle_cnt <= '0;
    else                                      idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout = (byte_cnt != '0) && !byte_busy && (idle_cnt == TW'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Bytes shift in from the top so the oldest ends up in the low lane.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt <= '0;
      partial  <= '0;
      rdata    <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (byte_ferr || timeout) begin
        byte_cnt <= '0;
      end else if (byte_done) begin
        byte_cnt <= byte_cnt + CNTW'(1);
        partial  <= {byte_data, partial[PW-1:UART_DATA_BITS]};
      end
      if (word_done && (!valid || ready)) begin
        rdata <= {byte_data, partial};
        valid <= 1'b1;
      end else begin
        if (valid && ready) valid <= 1'b0;
        if (word_done)      overrun <= 1'b1;
      end
    end
  end
endmodule
